// File: rtl/aes_enc_out_collector_if.sv
// aes_enc_out_collector_if: block intake, encryptor tap and ciphertext output of the collector
interface aes_enc_out_collector_if #(
  parameter int BLOCK_LENGTH = 128,
  parameter int ID_W = 4,
  parameter int PIPE_LATENCY = 11
);
  logic in_valid;
  logic in_ready;
  logic [BLOCK_LENGTH-1:0] in_data;
  logic [BLOCK_LENGTH-1:0] in_key;
  logic [ID_W-1:0] in_id;
  logic [BLOCK_LENGTH-1:0] enc_in;
  logic [BLOCK_LENGTH-1:0] enc_key;
  logic [BLOCK_LENGTH-1:0] enc_out;
  logic out_valid;
  logic out_ready;
  logic [BLOCK_LENGTH-1:0] out_data;
  logic [ID_W-1:0] out_id;
  logic [$clog2(PIPE_LATENCY+1)-1:0] inflight;
  logic overflow_err;
  modport master (
    output in_valid, in_data, in_key, in_id, enc_out, out_ready,
    input in_ready, enc_in, enc_key, out_valid, out_data, out_id, inflight, overflow_err
  );
  modport slave (
    input in_valid, in_data, in_key, in_id, enc_out, out_ready,
    output in_ready, enc_in, enc_key, out_valid, out_data, out_id, inflight, overflow_err
  );
endinterface

// File: rtl/aes_enc_out_collector.sv
// aes_enc_out_collector: launches blocks into a free-running AES pipe, tags them through its latency
// and buffers the ciphertext in a credit-guarded output FIFO
module aes_enc_out_collector #(
  parameter int BLOCK_LENGTH = 128,
  parameter int ID_W = 4,
  parameter int PIPE_LATENCY = 11,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  aes_enc_out_collector_if.slave bus
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CNT_W = FW + 1;
  localparam int CW = $clog2(PIPE_LATENCY + 1);
  localparam int EW = BLOCK_LENGTH + ID_W;
  localparam logic [FW:0] DEPTH = FIFO_DEPTH[FW:0];
  logic [PIPE_LATENCY-1:0][ID_W:0] tag_q, tag_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW:0] cnt_q, cnt_d, used;
  logic [CW-1:0] inflight_q, inflight_d;
  logic overflow_q, overflow_d;
  logic launch, capture, pop, full, wr;
  assign used = cnt_q + CNT_W'(inflight_q);
  // credits are reserved at launch, so a captured block always has a free slot
  assign bus.in_ready = (used != DEPTH) && !rst;
  assign bus.enc_in = bus.in_data;
  assign bus.enc_key = bus.in_key;
  assign bus.out_valid = cnt_q != '0;
  assign {bus.out_data, bus.out_id} = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.inflight = inflight_q;
  assign bus.overflow_err = overflow_q;
  always_comb begin
    launch = bus.in_valid && bus.in_ready;
    capture = tag_q[PIPE_LATENCY-1][ID_W];
    pop = bus.out_valid && bus.out_ready;
    full = cnt_q == DEPTH;
    wr = capture && (!full || pop);
    tag_d = {tag_q[PIPE_LATENCY-2:0], {launch, bus.in_id}};
    wr_ptr_d = wr_ptr_q + FW'(wr);
    rd_ptr_d = rd_ptr_q + FW'(pop);
    cnt_d = cnt_q + CNT_W'(wr) - CNT_W'(pop);
    inflight_d = inflight_q + CW'(launch) - CW'(capture);
    overflow_d = overflow_q || (capture && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {bus.enc_out, tag_q[PIPE_LATENCY-1][ID_W-1:0]};
  end
endmodule

// File: tb/tb_aes_enc_out_collector.sv
// tb_aes_enc_out_collector: directed checks of launch, capture, credits, FIFO order and reset
module tb_aes_enc_out_collector;
  localparam int BL = 128, IW = 4, PL = 11, FD = 16;
  localparam logic [BL-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BL-1:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BL-1:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0, n_err = 0, n_acc = 0, n_pop = 0;
  int lat, first, last, p_acc, p_pop;
  logic [BL+IW-1:0] exp_q [$];
  logic [BL-1:0] pipe [PL];
  always #5 clk = ~clk;
  aes_enc_out_collector_if #(.BLOCK_LENGTH(BL), .ID_W(IW), .PIPE_LATENCY(PL)) bus();
  aes_enc_out_collector #(.BLOCK_LENGTH(BL), .ID_W(IW), .PIPE_LATENCY(PL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  // stand-in encryptor: known FIPS-197 answer, otherwise a cheap reversible mix, PL cycles deep
  function automatic logic [BL-1:0] enc_f(input logic [BL-1:0] d, input logic [BL-1:0] k);
    return (d == FIPS_PT && k == FIPS_KEY) ? FIPS_CT : d ^ {k[63:0], k[127:64]} ^ 128'hc3a5_5a3c_0ff0_f00f_1234_5678_9abc_def0;
  endfunction
  always @(posedge clk) begin
    pipe[0] <= enc_f(bus.enc_in, bus.enc_key);
    for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.enc_out = pipe[PL-1];
  task automatic chk(input string tag, input logic [BL+IW-1:0] got, input logic [BL+IW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int s);
    bus.in_data = {4{32'(s) * 32'h9e3779b9}};
    bus.in_key = {4{32'(s) + 32'h01234567}};
    bus.in_id = IW'(s % 16);
  endtask
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({enc_f(bus.in_data, bus.in_key), bus.in_id});
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        chk("pop_expected", (BL+IW)'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("out_data", bus.out_data, exp_q[0][BL+IW-1:IW]);
          chk("out_id", bus.out_id, exp_q[0][IW-1:0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(0);
    tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_overflow", bus.overflow_err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data = FIPS_PT;
    bus.in_key = FIPS_KEY;
    bus.in_id = 4'd5;
    tick();
    chk("t1_inflight_1", bus.inflight, 1);
    bus.in_valid = 1'b0;
    drive(77);
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk("t1_latency", lat, 12);
    chk("t1_data", bus.out_data, FIPS_CT);
    chk("t1_id", bus.out_id, 5);
    chk("t1_inflight_0", bus.inflight, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t1_drained", bus.out_valid, 0);
    p_pop = n_pop;
    first = -1;
    last = -1;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      bus.in_valid = t < 40;
      drive(t + 100);
      bus.in_id = IW'(t % 16);
      if (t < 40) chk("t2_in_ready", bus.in_ready, 1);
      tick();
      if (bus.out_valid) begin
        if (first < 0) first = t;
        last = t;
      end
    end
    chk("t2_first", first, 11);
    chk("t2_span", last - first, 39);
    chk("t2_pops", n_pop - p_pop, 40);
    p_acc = n_acc;
    p_pop = n_pop;
    bus.out_ready = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bus.in_valid = 1'b1;
      drive(t + 200);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t3_accepted", n_acc - p_acc, 16);
    chk("t3_in_ready", bus.in_ready, 0);
    chk("t3_inflight", bus.inflight, 0);
    chk("t3_overflow", bus.overflow_err, 0);
    chk("t3_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    repeat (20) tick();
    chk("t3_drained", n_pop - p_pop, 16);
    chk("t3_empty", bus.out_valid, 0);
    chk("t3_recover", bus.in_ready, 1);
    p_acc = n_acc;
    p_pop = n_pop;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 40 && n_acc - p_acc < 15; i++) begin
      bus.in_valid = 1'b1;
      drive(i + 300);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t4_acc15", n_acc - p_acc, 15);
    repeat (12) tick();
    chk("t4_one_credit", bus.in_ready, 1);
    chk("t4_settled", bus.inflight, 0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    drive(350);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("t4_inflight", bus.inflight, 1);
    chk("t4_ready_after", bus.in_ready, 1);
    chk("t4_acc16", n_acc - p_acc, 16);
    chk("t4_pop1", n_pop - p_pop, 1);
    repeat (12) tick();
    chk("t4_ready_15", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    drive(351);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_no_credit", bus.in_ready, 0);
    repeat (12) tick();
    chk("t4_full_ready", bus.in_ready, 0);
    chk("t4_full_inflight", bus.inflight, 0);
    chk("t4_full_overflow", bus.overflow_err, 0);
    bus.out_ready = 1'b1;
    repeat (20) tick();
    chk("t4_drained", n_pop - p_pop, 17);
    chk("t4_empty", bus.out_valid, 0);
    chk("t4_overflow", bus.overflow_err, 0);
    chk("t4_recover", bus.in_ready, 1);
    p_pop = n_pop;
    for (int t = 0; t < 21; t++) begin
      bus.in_valid = t == 0 || t == 3 || t == 4;
      drive(t + 400);
      tick();
      chk("t5_valid", bus.out_valid, (t == 11 || t == 14 || t == 15) ? 1 : 0);
    end
    chk("t5_entries", n_pop - p_pop, 3);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    drive(500);
    tick();
    bus.in_valid = 1'b0;
    repeat (12) tick();
    chk("t6_pre_valid", bus.out_valid, 1);
    for (int t = 0; t < 6; t++) begin
      bus.in_valid = 1'b1;
      drive(t + 501);
      rst = t == 5;
      #1;
      if (t == 5) chk("t6_rst_in_ready", bus.in_ready, 0);
      tick();
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_out_data", bus.out_data, 0);
    chk("t6_out_id", bus.out_id, 0);
    chk("t6_inflight", bus.inflight, 0);
    chk("t6_overflow", bus.overflow_err, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("t6_quiet", bus.out_valid, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
